// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus for the sequential binary-to-BCD converter.
// The master issues requests; the slave (converter) returns digits and status.
interface bin2bcd_seq_if #(
    parameter int W = 6,
    parameter int D = 2
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic            start;
    logic [W-1:0]    bin;
    logic            busy;
    logic            done;
    logic [4*D-1:0]  bcd;
    logic [3:0]      msd;
    logic [PW-1:0]   msd_pos;
    logic            ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, msd, msd_pos, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, msd, msd_pos, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Also reports the most significant non-zero digit, its index and truncation.
module bin2bcd_seq #(
    parameter int W = 6,
    parameter int D = 2
) (
    input  logic           clk,
    input  logic           rst_b,
    bin2bcd_seq_if.slave   bus
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state_q;
    logic [4*D-1:0]  bcd_work_q;
    logic [W-1:0]    bin_work_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_work_q;
    logic            busy_q;
    logic            done_q;
    logic [4*D-1:0]  bcd_q;
    logic [3:0]      msd_q;
    logic [PW-1:0]   pos_q;
    logic            ovf_q;

    logic [4*D-1:0]  adj_d;
    logic [4*D-1:0]  bcd_shift_d;
    logic [W-1:0]    bin_shift_d;
    logic            ovf_shift_d;
    logic [3:0]      msd_d;
    logic [PW-1:0]   pos_d;

    // One double-dabble step: add 3 to digits >= 5, then shift the whole word left.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        adj_d = bcd_work_q;
        for (int k = 0; k < D; k++) begin
            if (bcd_work_q[4*k +: 4] >= 4'd5)
                adj_d[4*k +: 4] = bcd_work_q[4*k +: 4] + 4'd3;
        end
        {bcd_shift_d, bin_shift_d} = {adj_d[4*D-2:0], bin_work_q, 1'b0};
        ovf_shift_d = ovf_work_q | adj_d[4*D-1];

        // Ascending scan: the last non-zero digit seen is the most significant one.
        msd_d = 4'd0;
        pos_d = '0;
        for (int k = 0; k < D; k++) begin
            if (bcd_shift_d[4*k +: 4] != 4'd0) begin
                msd_d = bcd_shift_d[4*k +: 4];
                pos_d = PW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
        if (!rst_b) begin
            state_q    <= IDLE;
            bcd_work_q <= '0;
            bin_work_q <= '0;
            cnt_q      <= '0;
            ovf_work_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            msd_q      <= 4'd0;
            pos_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bcd_work_q <= '0;
                        bin_work_q <= bus.bin;
                        cnt_q      <= CW'(W);
                        ovf_work_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    bcd_work_q <= bcd_shift_d;
                    bin_work_q <= bin_shift_d;
                    ovf_work_q <= ovf_shift_d;
                    cnt_q      <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= bcd_shift_d;
                        ovf_q   <= ovf_shift_d;
                        msd_q   <= msd_d;
                        pos_q   <= pos_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd     = bcd_q;
    assign bus.msd     = msd_q;
    assign bus.msd_pos = pos_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (W/D = 6/2, 7/2, 10/4) share clock and reset.
// Expected results come from a division-based decimal model and are popped when done fires.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq_if #(.W(6),  .D(2)) ia();
    bin2bcd_seq_if #(.W(7),  .D(2)) ib();
    bin2bcd_seq_if #(.W(10), .D(4)) ic();

    bin2bcd_seq #(.W(6),  .D(2)) dut_a (.clk(clk), .rst_b(rst_b), .bus(ia));
    bin2bcd_seq #(.W(7),  .D(2)) dut_b (.clk(clk), .rst_b(rst_b), .bus(ib));
    bin2bcd_seq #(.W(10), .D(4)) dut_c (.clk(clk), .rst_b(rst_b), .bus(ic));

    typedef struct {
        int          id;
        logic [15:0] bcd;
        logic [3:0]  msd;
        logic [1:0]  pos;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input int id);
        return (id == 0) ? 6 : (id == 1) ? 7 : 10;
    endfunction

    function automatic int d_of(input int id);
        return (id == 2) ? 4 : 2;
    endfunction

    function automatic exp_t model(input int id, input int v, input int at_cyc);
        exp_t e;
        int   m = 1;
        int   r;
        int   dig;
        repeat (d_of(id)) m *= 10;
        e.id  = id;
        e.cyc = at_cyc;
        e.ovf = (v >= m);
        e.bcd = '0;
        e.msd = '0;
        e.pos = '0;
        r = v % m;
        for (int k = 0; k < d_of(id); k++) begin
            dig = r % 10;
            r   = r / 10;
            e.bcd[4*k +: 4] = 4'(dig);
            if (dig != 0) begin
                e.msd = 4'(dig);
                e.pos = 2'(k);
            end
        end
        return e;
    endfunction

    function automatic logic done_of(input int id);
        case (id)
            0:       return ia.done;
            1:       return ib.done;
            default: return ic.done;
        endcase
    endfunction

    function automatic logic busy_of(input int id);
        case (id)
            0:       return ia.busy;
            1:       return ib.busy;
            default: return ic.busy;
        endcase
    endfunction

    function automatic exp_t got_of(input int id);
        exp_t g;
        g.id  = id;
        g.cyc = cyc;
        case (id)
            0: begin g.bcd = 16'(ia.bcd); g.msd = ia.msd; g.pos = 2'(ia.msd_pos); g.ovf = ia.ovf; end
            1: begin g.bcd = 16'(ib.bcd); g.msd = ib.msd; g.pos = 2'(ib.msd_pos); g.ovf = ib.ovf; end
            default: begin g.bcd = 16'(ic.bcd); g.msd = ic.msd; g.pos = 2'(ic.msd_pos); g.ovf = ic.ovf; end
        endcase
        return g;
    endfunction

    // Called at a falling edge; start is held for exactly one rising edge.
    task automatic drive(input int id, input int v, input bit accept);
        case (id)
            0:       begin ia.start = 1'b1; ia.bin = 6'(v);  end
            1:       begin ib.start = 1'b1; ib.bin = 7'(v);  end
            default: begin ic.start = 1'b1; ic.bin = 10'(v); end
        endcase
        if (accept) sb.push_back(model(id, v, cyc + 1 + w_of(id)));
        @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
        ic.start = 1'b0;
        if (accept) check("busy_after_start", busy_of(id), 1'b1);
    endtask

    task automatic wait_done(input int id);
        int n = 0;
        while (!done_of(id) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) check("done_timeout", done_of(id), 1'b1);
    endtask

    logic dprev [3];
    initial for (int i = 0; i < 3; i++) dprev[i] = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        for (int id = 0; id < 3; id++) begin
            if (done_of(id)) begin
                if (sb.size() > 0 && sb[0].id == id) begin
                    e = sb.pop_front();
                    g = got_of(id);
                    check("bcd",        32'(g.bcd), 32'(e.bcd));
                    check("msd",        32'(g.msd), 32'(e.msd));
                    check("msd_pos",    32'(g.pos), 32'(e.pos));
                    check("ovf",        32'(g.ovf), 32'(e.ovf));
                    check("latency",    g.cyc, e.cyc);
                    check("busy_on_done", busy_of(id), 1'b0);
                    check("done_width", dprev[id], 1'b0);
                end else begin
                    check("spurious_done", done_of(id), 1'b0);
                end
            end
            dprev[id] = done_of(id);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b    = 1'b0;
        ia.start = 1'b0; ia.bin = '0;
        ib.start = 1'b0; ib.bin = '0;
        ic.start = 1'b0; ic.bin = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",  ia.busy, 1'b0);
        check("rst_done",  ia.done, 1'b0);
        check("rst_bcd",   ia.bcd, 0);
        check("rst_msd",   ia.msd, 0);
        check("rst_pos",   ia.msd_pos, 0);
        check("rst_ovf",   ia.ovf, 1'b0);
        rst_b = 1'b1;
        @(negedge clk);

        // Full sweep; odd values start on the done cycle, even ones after an idle cycle.
        drive(0, 0, 1'b1);
        wait_done(0);
        for (int v = 1; v < 64; v++) begin
            if (v % 2 == 0) @(negedge clk);
            drive(0, v, 1'b1);
            wait_done(0);
        end

        // Start while busy is ignored; start on the done cycle is accepted.
        @(negedge clk);
        drive(0, 42, 1'b1);
        @(negedge clk);
        drive(0, 17, 1'b0);
        wait_done(0);
        drive(0, 17, 1'b1);
        wait_done(0);

        // Reset mid-conversion abandons it with no done pulse.
        @(negedge clk);
        drive(0, 55, 1'b1);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_busy", ia.busy, 1'b0);
        check("midrst_done", ia.done, 1'b0);
        check("midrst_bcd",  ia.bcd, 0);
        check("midrst_msd",  ia.msd, 0);
        check("midrst_ovf",  ia.ovf, 1'b0);
        rst_b = 1'b1;
        repeat (15) @(negedge clk);
        drive(0, 20, 1'b1);
        wait_done(0);

        // Truncation with W=7, D=2.
        @(negedge clk);
        drive(1, 100, 1'b1);
        wait_done(1);
        @(negedge clk);
        drive(1, 99, 1'b1);
        wait_done(1);
        @(negedge clk);
        drive(1, 127, 1'b1);
        wait_done(1);

        // Wide case W=10, D=4.
        @(negedge clk);
        drive(2, 1023, 1'b1);
        wait_done(2);
        @(negedge clk);
        drive(2, 305, 1'b1);
        wait_done(2);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
